// File: rtl/saes_iter_core_if.sv
// Request/result handshake bundle for the iterative S-AES core.
// The core connects through the slave modport; the requester uses master.
interface saes_iter_core_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic [15:0] in_key;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;

    modport master (
        output in_valid, in_mode, in_key, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_mode, in_key, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/saes_iter_core.sv
// Iterative Simplified-AES encrypt/decrypt core: one round per cycle, with an
// optional round-key cache that lets a repeated key skip the expansion cycle.
module saes_iter_core #(
    parameter int unsigned SKIP_KEYEXP = 1
) (
    input logic            clk,
    input logic            rst_n,
    saes_iter_core_if.slave bus
);

    typedef enum logic [2:0] {IDLE, KEY, R0, R1, R2, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        mode_r;
    logic [15:0] key_r;
    logic [15:0] st;
    logic [15:0] k0;
    logic [15:0] k1;
    logic [15:0] k2;
    logic        key_valid;
    logic        accept;
    logic        key_hit;

    function automatic logic [3:0] sbox(input logic [3:0] n);
        case (n)
            4'h0: return 4'h9;  4'h1: return 4'h4;  4'h2: return 4'hA;  4'h3: return 4'hB;
            4'h4: return 4'hD;  4'h5: return 4'h1;  4'h6: return 4'h8;  4'h7: return 4'h5;
            4'h8: return 4'h6;  4'h9: return 4'h2;  4'hA: return 4'h0;  4'hB: return 4'h3;
            4'hC: return 4'hC;  4'hD: return 4'hE;  4'hE: return 4'hF;  default: return 4'h7;
        endcase
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] n);
        case (n)
            4'h0: return 4'hA;  4'h1: return 4'h5;  4'h2: return 4'h9;  4'h3: return 4'hB;
            4'h4: return 4'h1;  4'h5: return 4'h7;  4'h6: return 4'h8;  4'h7: return 4'hF;
            4'h8: return 4'h6;  4'h9: return 4'h0;  4'hA: return 4'h2;  4'hB: return 4'h3;
            4'hC: return 4'hC;  4'hD: return 4'h4;  4'hE: return 4'hD;  default: return 4'hE;
        endcase
    endfunction

    function automatic logic [15:0] sub_nib(input logic [15:0] s);
        return {sbox(s[15:12]), sbox(s[11:8]), sbox(s[7:4]), sbox(s[3:0])};
    endfunction

    function automatic logic [15:0] inv_sub_nib(input logic [15:0] s);
        return {inv_sbox(s[15:12]), inv_sbox(s[11:8]), inv_sbox(s[7:4]), inv_sbox(s[3:0])};
    endfunction

    // Row 1 of the 2x2 state is nibbles s10 and s11.
    function automatic logic [15:0] shift_row(input logic [15:0] s);
        return {s[15:12], s[3:0], s[7:4], s[11:8]};
    endfunction

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] x;
        p = 4'h0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    function automatic logic [15:0] mix_col(input logic [15:0] s);
        return {s[15:12] ^ gf_mul(4'h4, s[11:8]), gf_mul(4'h4, s[15:12]) ^ s[11:8],
                s[7:4] ^ gf_mul(4'h4, s[3:0]),    gf_mul(4'h4, s[7:4]) ^ s[3:0]};
    endfunction

    function automatic logic [15:0] inv_mix_col(input logic [15:0] s);
        return {gf_mul(4'h9, s[15:12]) ^ gf_mul(4'h2, s[11:8]),
                gf_mul(4'h2, s[15:12]) ^ gf_mul(4'h9, s[11:8]),
                gf_mul(4'h9, s[7:4])   ^ gf_mul(4'h2, s[3:0]),
                gf_mul(4'h2, s[7:4])   ^ gf_mul(4'h9, s[3:0])};
    endfunction

    function automatic logic [7:0] sub_rot(input logic [7:0] b);
        return {sbox(b[3:0]), sbox(b[7:4])};
    endfunction

    // Returns {K1, K2}; K0 is the key itself.
    function automatic logic [31:0] key_expand(input logic [15:0] key);
        logic [7:0] w2;
        logic [7:0] w3;
        logic [7:0] w4;
        logic [7:0] w5;
        w2 = key[15:8] ^ 8'h80 ^ sub_rot(key[7:0]);
        w3 = w2 ^ key[7:0];
        w4 = w2 ^ 8'h30 ^ sub_rot(w3);
        w5 = w4 ^ w3;
        return {w2, w3, w4, w5};
    endfunction

    assign bus.in_ready = rst_n && (state == IDLE);
    assign accept       = bus.in_valid && bus.in_ready;
    assign key_hit      = (SKIP_KEYEXP != 0) && key_valid && (bus.in_key == k0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.busy      = 1'b1;
        bus.out_valid = 1'b0;
        bus.out_data  = 16'h0000;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (accept) state_nxt = key_hit ? R0 : KEY;
            end
            KEY:  state_nxt = R0;
            R0:   state_nxt = R1;
            R1:   state_nxt = R2;
            R2:   state_nxt = DONE;
            DONE: begin
                bus.out_valid = 1'b1;
                bus.out_data  = st;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The cache survives mode changes; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k0        <= 16'h0000;
            k1        <= 16'h0000;
            k2        <= 16'h0000;
            key_valid <= 1'b0;
        end else if (state == KEY) begin
            k0        <= key_r;
            {k1, k2}  <= key_expand(key_r);
            key_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mode_r <= bus.in_mode;
            key_r  <= bus.in_key;
            st     <= bus.in_data;
        end else begin
            case (state)
                R0: st <= st ^ (mode_r ? k2 : k0);
                R1: st <= mode_r ? inv_mix_col(inv_sub_nib(shift_row(st)) ^ k1)
                                 : mix_col(shift_row(sub_nib(st))) ^ k1;
                R2: st <= mode_r ? inv_sub_nib(shift_row(st)) ^ k0
                                 : shift_row(sub_nib(st)) ^ k2;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/saes_iter_core.md
SAES_ITER_CORE -- requirements
Module: saes_iter_core

Interface
REQ-001 SHALL have parameter SKIP_KEYEXP, default 1, meaning: when 1, the KEY state is skipped if the new key equals the cached key and the cache is valid.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  core can accept a request.
REQ-006 SHALL have port in_mode  input  1  0 = encrypt, 1 = decrypt.
REQ-007 SHALL have port in_key  input  16  cipher key w0||w1.
REQ-008 SHALL have port in_data  input  16  plaintext or ciphertext; nibbles [15:12],[11:8],[7:4],[3:0] = s00,s10,s01,s11.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out_data  output  16  result.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL use FSM states IDLE, KEY, R0, R1, R2, DONE.
REQ-014 in_ready SHALL equal (state==IDLE); a request is accepted on a rising edge with in_valid && in_ready.
REQ-015 On acceptance, SHALL register in_mode, in_key, in_data and go to KEY; with SKIP_KEYEXP=1, key_cache_valid=1 and in_key==cached key, SHALL go directly to R0.
REQ-016 KEY (1 cycle): SHALL instantiate KeySchedule on the registered key, register K0=key, K1, K2, set key_cache_valid=1, then go to R0.
REQ-017 Encrypt: R0 state^=K0; R1 state=MixCol(ShiftRow(SubNib(state)))^K1; R2 state=ShiftRow(SubNib(state))^K2.
REQ-018 Decrypt: R0 state^=K2; R1 state=InvMixCol(InvSubNib(ShiftRow(state))^K1); R2 state=InvSubNib(ShiftRow(state))^K0.
REQ-019 SubNib SHALL apply the S-AES S-box (SBoxEncrypt) per nibble; InvSubNib SHALL apply the S-AES inverse S-box; ShiftRow swaps nibbles [11:8] and [3:0].
REQ-020 MixCol per column (a,b) SHALL yield (a^4b, 4a^b); InvMixCol SHALL yield (9a^2b, 2a^9b); multiplies in GF(16) mod x^4+x+1.
REQ-021 Each of R0, R1, R2 SHALL last exactly one cycle; R2 goes to DONE.
REQ-022 Latency: out_valid SHALL rise 4 cycles after the accepting edge with key expansion, 3 cycles when skipped.
REQ-023 In DONE, out_valid=1 and out_data=state, held stable until out_valid && out_ready, then go to IDLE.
REQ-024 in_ready SHALL stay 0 in DONE; no same-cycle accept-on-release (one idle cycle between jobs minimum).
REQ-025 in_valid and input changes while busy SHALL be ignored; registered operands SHALL not change mid-job.
REQ-026 out_data SHALL be 16'h0000 whenever out_valid=0.
REQ-027 Mode SHALL not invalidate the key cache; encrypt and decrypt share K0..K2.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, in_ready=1 only after rst_n=1, out_valid=0, out_data=0, busy=0, key_cache_valid=0, K0..K2=0.
REQ-029 Reset asserted mid-job SHALL abort the job with no out_valid pulse; the next job after release SHALL run the KEY state.
REQ-030 While rst_n=0, in_ready SHALL be 0.

Verification
REQ-031 Encrypt key=4AF5, data=D728, fresh cache -> out_valid 4 cycles after accept, out_data=24EC.
REQ-032 Decrypt key=4AF5, data=24EC immediately after REQ-031 (SKIP_KEYEXP=1) -> KEY skipped, out_valid after 3 cycles, out_data=D728.
REQ-033 Hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> out_valid and out_data=24EC stable, in_ready=0, no new accept; accept occurs only after release plus one IDLE cycle.
REQ-034 Assert rst_n=0 in R1, release, then re-encrypt D728/4AF5 -> no out_valid during abort, KEY visited, out_data=24EC.
REQ-035 SKIP_KEYEXP=0, two back-to-back jobs same key -> KEY visited both times, latency 4 each.
REQ-036 Change in_key/in_data while busy -> result unchanged (24EC for REQ-031 operands).
